// File: rtl/if_id_elastic.sv
// Elastic IF/ID stage: main entry plus one skid entry behind a valid/ready handshake,
// with flush-to-bubble, hazard stall and a saturating bubble-cycle counter.
module if_id_elastic #(
   parameter int                  PC_SIZE   = 32,
   parameter int                  BUS_SIZE  = 32,
   parameter logic [BUS_SIZE-1:0] NOP_INSTR = '0,
   parameter int                  CNT_WIDTH = 16
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 i_flush,
   input  logic                 i_stall,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [PC_SIZE-1:0]   i_next_seq_pc,
   input  logic [BUS_SIZE-1:0]  i_instruction,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [PC_SIZE-1:0]   o_next_seq_pc,
   output logic [BUS_SIZE-1:0]  o_instruction,
   output logic [1:0]           o_occupancy,
   output logic [CNT_WIDTH-1:0] o_bubble_count,
   input  logic                 i_count_clear
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [BUS_SIZE-1:0]  main_instr_q, main_instr_d;
   logic [PC_SIZE-1:0]   main_pc_q, main_pc_d;
   logic [BUS_SIZE-1:0]  skid_instr_q, skid_instr_d;
   logic [PC_SIZE-1:0]   skid_pc_q, skid_pc_d;
   logic [CNT_WIDTH-1:0] bubble_q, bubble_d;
   logic                 push;
   logic                 pop;

   // Handshake flags depend only on registered state, never on i_ready.
   assign o_ready = (state_q != ST_FULL);
   assign o_valid = (state_q != ST_EMPTY);
   assign push    = i_valid & o_ready;
   assign pop     = o_valid & i_ready & ~i_stall;

   always_comb begin
      state_d      = state_q;
      main_instr_d = main_instr_q;
      main_pc_d    = main_pc_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      if (i_flush) begin
         state_d      = ST_EMPTY;
         main_instr_d = NOP_INSTR;
         main_pc_d    = '0;
         skid_instr_d = NOP_INSTR;
         skid_pc_d    = '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (push) begin
                  state_d      = ST_ONE;
                  main_instr_d = i_instruction;
                  main_pc_d    = i_next_seq_pc;
               end
            end
            ST_ONE: begin
               if (push && pop) begin
                  main_instr_d = i_instruction;
                  main_pc_d    = i_next_seq_pc;
               end else if (push) begin
                  state_d      = ST_FULL;
                  skid_instr_d = i_instruction;
                  skid_pc_d    = i_next_seq_pc;
               end else if (pop) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (pop) begin
                  state_d      = ST_ONE;
                  main_instr_d = skid_instr_q;
                  main_pc_d    = skid_pc_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_comb begin
      bubble_d = bubble_q;
      if (i_count_clear) begin
         bubble_d = '0;
      end else if (!o_valid && (bubble_q != {CNT_WIDTH{1'b1}})) begin
         bubble_d = bubble_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q      <= ST_EMPTY;
         main_instr_q <= NOP_INSTR;
         main_pc_q    <= '0;
         skid_instr_q <= NOP_INSTR;
         skid_pc_q    <= '0;
         bubble_q     <= '0;
      end else begin
         state_q      <= state_d;
         main_instr_q <= main_instr_d;
         main_pc_q    <= main_pc_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         bubble_q     <= bubble_d;
      end
   end

   always_comb begin
      case (state_q)
         ST_ONE:  o_occupancy = 2'd1;
         ST_FULL: o_occupancy = 2'd2;
         default: o_occupancy = 2'd0;
      endcase
   end

   assign o_instruction  = o_valid ? main_instr_q : NOP_INSTR;
   assign o_next_seq_pc  = main_pc_q;
   assign o_bubble_count = bubble_q;

endmodule

// File: tb/tb_if_id_elastic.sv
// Bench for if_id_elastic: directed vector table, hand-written corner sequences and
// random traffic, all compared against a queue-based model of the stage.
module tb_if_id_elastic;

   localparam int          PW   = 32;
   localparam int          BW   = 32;
   localparam int          CW   = 4;
   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [3:0]  CMAX = 4'hF;

   logic          i_clk = 1'b0;
   logic          i_reset_n = 1'b0;
   logic          i_flush = 1'b0;
   logic          i_stall = 1'b0;
   logic          i_valid = 1'b0;
   logic          o_ready;
   logic [PW-1:0] i_next_seq_pc = '0;
   logic [BW-1:0] i_instruction = '0;
   logic          o_valid;
   logic          i_ready = 1'b0;
   logic [PW-1:0] o_next_seq_pc;
   logic [BW-1:0] o_instruction;
   logic [1:0]    o_occupancy;
   logic [CW-1:0] o_bubble_count;
   logic          i_count_clear = 1'b0;

   int checks = 0;
   int errors = 0;

   if_id_elastic #(
      .PC_SIZE(PW), .BUS_SIZE(BW), .NOP_INSTR(NOP), .CNT_WIDTH(CW)
   ) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush), .i_stall(i_stall),
      .i_valid(i_valid), .o_ready(o_ready), .i_next_seq_pc(i_next_seq_pc),
      .i_instruction(i_instruction), .o_valid(o_valid), .i_ready(i_ready),
      .o_next_seq_pc(o_next_seq_pc), .o_instruction(o_instruction),
      .o_occupancy(o_occupancy), .o_bubble_count(o_bubble_count),
      .i_count_clear(i_count_clear)
   );

   always #5 i_clk = ~i_clk;

   // Reference model: a FIFO of at most two words plus the visible PC and counter.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } entry_t;

   entry_t      mq[$];
   logic [31:0] m_pc;
   int          m_cnt;

   typedef struct {
      logic        v, r, s, f, c;
      logic [31:0] ins;
      logic        ev, er;
      logic [1:0]  eo;
      logic [31:0] ei;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [31:0] pc_of(input logic [31:0] ins);
      return ins * 4 + 32'h0000_4000;
   endfunction

   function automatic vec_t mk(input logic v, r, s, f, c, input logic [31:0] ins,
                               input logic ev, er, input logic [1:0] eo,
                               input logic [31:0] ei);
      vec_t t;
      t.v = v; t.r = r; t.s = s; t.f = f; t.c = c; t.ins = ins;
      t.ev = ev; t.er = er; t.eo = eo; t.ei = ei;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      logic [31:0] e_ins;
      e_ins = (mq.size() > 0) ? mq[0].ins : NOP;
      chk({tag, " valid"}, {31'd0, o_valid}, {31'd0, mq.size() > 0});
      chk({tag, " ready"}, {31'd0, o_ready}, {31'd0, mq.size() < 2});
      chk({tag, " occ"}, {30'd0, o_occupancy}, 32'(mq.size()));
      chk({tag, " instr"}, o_instruction, e_ins);
      chk({tag, " pc"}, o_next_seq_pc, m_pc);
      chk({tag, " bubbles"}, {28'd0, o_bubble_count}, 32'(m_cnt));
   endtask

   // Drive one cycle of inputs, advance the model, then compare after the edge.
   task automatic step(input logic v, r, s, f, c, input logic [31:0] ins);
      bit     push, pop;
      entry_t e;
      i_valid = v; i_ready = r; i_stall = s; i_flush = f; i_count_clear = c;
      i_instruction = ins; i_next_seq_pc = pc_of(ins);
      push = v && (mq.size() < 2);
      pop  = (mq.size() > 0) && r && !s;
      if (c) m_cnt = 0;
      else if (mq.size() == 0 && m_cnt < int'(CMAX)) m_cnt++;
      if (pop) $display("xfer pc=%h instr=%h%s", mq[0].pc, mq[0].ins, f ? " (flush)" : "");
      if (f) begin
         mq.delete();
         m_pc = '0;
      end else begin
         if (pop) void'(mq.pop_front());
         if (push) begin
            e.pc = pc_of(ins); e.ins = ins;
            mq.push_back(e);
         end
         if (mq.size() > 0) m_pc = mq[0].pc;
      end
      @(posedge i_clk);
      #1;
      check_model("model");
   endtask

   // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge.
   task automatic async_reset(input string tag);
      i_valid = 1'b0; i_ready = 1'b0; i_stall = 1'b0; i_flush = 1'b0; i_count_clear = 1'b0;
      #1 i_reset_n = 1'b0;
      #1;
      chk({tag, " rst valid"}, {31'd0, o_valid}, 32'd0);
      chk({tag, " rst ready"}, {31'd0, o_ready}, 32'd1);
      chk({tag, " rst occ"}, {30'd0, o_occupancy}, 32'd0);
      chk({tag, " rst instr"}, o_instruction, NOP);
      chk({tag, " rst pc"}, o_next_seq_pc, 32'd0);
      chk({tag, " rst bubbles"}, {28'd0, o_bubble_count}, 32'd0);
      #1 i_reset_n = 1'b1;
      mq.delete();
      m_pc = '0;
      m_cnt = 0;
   endtask

   initial begin
      for (int k = 1; k <= 8; k++) tbl.push_back(mk(1, 1, 0, 0, 0, 32'(k), 1, 1, 2'd1, 32'(k)));
      tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0, 0, 1, 2'd0, NOP));
      tbl.push_back(mk(1, 0, 0, 0, 0, 32'hA, 1, 1, 2'd1, 32'hA));
      tbl.push_back(mk(1, 0, 0, 0, 0, 32'hB, 1, 0, 2'd2, 32'hA));
      for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 1, 1, 0, 0, 32'h0, 1, 0, 2'd2, 32'hA));
      tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0, 1, 1, 2'd1, 32'hB));
      tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0, 0, 1, 2'd0, NOP));
      tbl.push_back(mk(1, 0, 0, 0, 0, 32'hA, 1, 1, 2'd1, 32'hA));
      tbl.push_back(mk(1, 0, 0, 0, 0, 32'hB, 1, 0, 2'd2, 32'hA));
      tbl.push_back(mk(1, 0, 0, 1, 0, 32'hC, 0, 1, 2'd0, NOP));
      tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0, 0, 1, 2'd0, NOP));

      // Reset held low across a clock edge.
      @(posedge i_clk);
      #1;
      chk("reset valid", {31'd0, o_valid}, 32'd0);
      chk("reset ready", {31'd0, o_ready}, 32'd1);
      chk("reset instr", o_instruction, NOP);
      chk("reset occ", {30'd0, o_occupancy}, 32'd0);
      chk("reset bubbles", {28'd0, o_bubble_count}, 32'd0);
      i_reset_n = 1'b1;
      m_pc = '0;
      m_cnt = 0;

      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].c, tbl[i].ins);
         chk($sformatf("vec%0d valid", i), {31'd0, o_valid}, {31'd0, tbl[i].ev});
         chk($sformatf("vec%0d ready", i), {31'd0, o_ready}, {31'd0, tbl[i].er});
         chk($sformatf("vec%0d occ", i), {30'd0, o_occupancy}, {30'd0, tbl[i].eo});
         chk($sformatf("vec%0d instr", i), o_instruction, tbl[i].ei);
      end
      chk("flush pc", o_next_seq_pc, 32'd0);

      // Bubble counter saturation and clear.
      async_reset("cnt");
      for (int k = 0; k < 20; k++) step(0, 0, 0, 0, 0, 32'h0);
      chk("bubble saturated", {28'd0, o_bubble_count}, 32'd15);
      step(0, 0, 0, 0, 1, 32'h0);
      chk("bubble cleared", {28'd0, o_bubble_count}, 32'd0);
      step(0, 0, 0, 0, 0, 32'h0);
      chk("bubble restart", {28'd0, o_bubble_count}, 32'd1);

      // Reset arriving while the stage is full.
      step(1, 0, 0, 0, 0, 32'hA);
      step(1, 0, 0, 0, 0, 32'hB);
      async_reset("mid");
      step(0, 1, 0, 0, 0, 32'h0);

      // Random traffic against the model.
      for (int k = 0; k < 600; k++) begin
         step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 65,
              $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5,
              $urandom_range(0, 99) < 3, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
